// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake/result bundle for the pipelined LEGv8 immediate generator.
//
// Signals:
//   in_valid   producer -> stage   instr is valid this cycle
//   in_ready   stage -> producer   stage can accept instr this cycle
//   instr      producer -> stage   32-bit instruction word
//   out_valid  stage -> consumer   imm/fmt/err hold a valid result
//   out_ready  consumer -> stage   consumer accepts the result this cycle
//   imm        stage -> consumer   extended immediate, N bits
//   fmt        stage -> consumer   0 NONE, 1 D, 2 CB, 3 B, 4 I
//   err        stage -> consumer   result came from an unrecognised opcode
//   err_count  stage -> consumer   saturating count of accepted bad opcodes
//
// Modports:
//   master  the environment (drives instr side, consumes result side)
//   slave   the immediate generator stage
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int N         = 64,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         imm;
    logic [2:0]           fmt;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid,
        output instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  imm,
        input  fmt,
        input  err,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output imm,
        output fmt,
        output err,
        output err_count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator for the LEGv8 datapath. Decodes D, CB, B and
// I formats from a 32-bit instruction word, sign- or zero-extends the
// immediate to N bits and delivers it through a single valid/ready register
// stage together with a format tag, an error flag and a saturating count of
// accepted unrecognised instructions.
//
// Parameters:
//   N             output immediate width, must be >= 32
//   SHIFT_BRANCH  1: CB/B offsets are shifted left by 2 before extension
//   ERR_CNT_W     width of the saturating error counter
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous, active-high reset
//   bus    imm_gen_pipe_if.slave: in_valid/in_ready/instr in,
//          out_valid/out_ready/imm/fmt/err/err_count out
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int N            = 64,
    parameter int SHIFT_BRANCH = 0,
    parameter int ERR_CNT_W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    imm_gen_pipe_if.slave bus
);

    // Reject widths too narrow to hold the sign-extended branch offsets.
    if (N < 32'sd32) begin : g_bad_n
        $error("imm_gen_pipe: N must be at least 32");
    end

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_D    = 3'd1;
    localparam logic [2:0] FMT_CB   = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_I    = 3'd4;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1'b1);

    // Output register stage.
    logic                 out_valid_r;
    logic [N-1:0]         imm_r;
    logic [2:0]           fmt_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_count_r;

    // Handshake and decode results.
    logic                 in_ready_s;
    logic                 accept_s;
    logic [N-1:0]         d_sext_s;
    logic [N-1:0]         cb_sext_s;
    logic [N-1:0]         b_sext_s;
    logic [N-1:0]         i_zext_s;
    logic [N-1:0]         dec_imm_s;
    logic [2:0]           dec_fmt_s;
    logic                 dec_err_s;

    // A new word may enter whenever the register is empty or being drained.
    always_comb begin
        in_ready_s = !out_valid_r || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Candidate immediates for every format. For the branch formats, shifting
    // the sign-extended value left by two is identical to sign-extending the
    // shifted field, because N leaves headroom above the 28-bit B field.
    always_comb begin
        d_sext_s  = {{(N-9){bus.instr[20]}}, bus.instr[20:12]};
        i_zext_s  = N'(bus.instr[21:10]);
        cb_sext_s = {{(N-19){bus.instr[23]}}, bus.instr[23:5]};
        b_sext_s  = {{(N-26){bus.instr[25]}}, bus.instr[25:0]};
        if (SHIFT_BRANCH != 32'sd0) begin
            cb_sext_s = {cb_sext_s[N-3:0], 2'b00};
            b_sext_s  = {b_sext_s[N-3:0], 2'b00};
        end else begin
            cb_sext_s = cb_sext_s;
            b_sext_s  = b_sext_s;
        end
    end

    // Priority decode of the opcode field; first match wins.
    always_comb begin
        dec_imm_s = {N{1'b0}};
        dec_fmt_s = FMT_NONE;
        dec_err_s = 1'b0;
        if ((bus.instr[31:21] == 11'h7C2) || (bus.instr[31:21] == 11'h7C0)) begin
            dec_imm_s = d_sext_s;
            dec_fmt_s = FMT_D;
        end else if ((bus.instr[31:24] == 8'hB4) || (bus.instr[31:24] == 8'hB5)) begin
            dec_imm_s = cb_sext_s;
            dec_fmt_s = FMT_CB;
        end else if (bus.instr[31:26] == 6'b000101) begin
            dec_imm_s = b_sext_s;
            dec_fmt_s = FMT_B;
        end else if ((bus.instr[31:22] == 10'b1001000100) ||
                     (bus.instr[31:22] == 10'b1101000100)) begin
            dec_imm_s = i_zext_s;
            dec_fmt_s = FMT_I;
        end else begin
            dec_imm_s = {N{1'b0}};
            dec_fmt_s = FMT_NONE;
            dec_err_s = 1'b1;
        end
    end

    // Result register: load on accept, clear valid on a drain with no refill,
    // otherwise hold so the consumer sees a stable value while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            imm_r       <= {N{1'b0}};
            fmt_r       <= FMT_NONE;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            imm_r       <= dec_imm_s;
            fmt_r       <= dec_fmt_s;
            err_r       <= dec_err_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Error counter advances at accept time and saturates at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (accept_s && dec_err_s && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_ONE;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.imm       = imm_r;
    assign bus.fmt       = fmt_r;
    assign bus.err       = err_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed, table-driven bench for imm_gen_pipe. Three instances:
//   dut0  N=64, SHIFT_BRANCH=0, ERR_CNT_W=8
//   dut1  N=64, SHIFT_BRANCH=1, ERR_CNT_W=8  (same stimulus as dut0)
//   dut2  N=32, SHIFT_BRANCH=0, ERR_CNT_W=2  (counter saturation)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic clk;
    logic reset;

    imm_gen_pipe_if #(.N(64), .ERR_CNT_W(8)) if0 ();
    imm_gen_pipe_if #(.N(64), .ERR_CNT_W(8)) if1 ();
    imm_gen_pipe_if #(.N(32), .ERR_CNT_W(2)) if2 ();

    imm_gen_pipe #(.N(64), .SHIFT_BRANCH(0), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    imm_gen_pipe #(.N(64), .SHIFT_BRANCH(1), .ERR_CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    imm_gen_pipe #(.N(32), .SHIFT_BRANCH(0), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm0;   // expected with SHIFT_BRANCH=0
        logic [63:0] imm1;   // expected with SHIFT_BRANCH=1
        logic [2:0]  fmt;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int exp_cnt;
        logic [63:0] stream [4];

        vecs[0] = '{32'hF84FFFFF, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 3'd1, 1'b0};
        vecs[1] = '{32'hF8500000, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF00, 3'd1, 1'b0};
        vecs[2] = '{32'hF80FFFFF, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 3'd1, 1'b0};
        vecs[3] = '{32'hB47FFFFF, 64'h0000_0000_0003_FFFF, 64'h0000_0000_000F_FFFC, 3'd2, 1'b0};
        vecs[4] = '{32'hB5FFFFE0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
        vecs[5] = '{32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vecs[6] = '{32'h913FFC00, 64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_0FFF, 3'd4, 1'b0};
        vecs[7] = '{32'hF83FFFFF, 64'h0,                   64'h0,                   3'd0, 1'b1};
        vecs[8] = '{32'hBC1FFFFF, 64'h0,                   64'h0,                   3'd0, 1'b1};

        n_total = 0;
        n_pass  = 0;
        exp_cnt = 0;

        reset = 1'b1;
        if0.in_valid = 1'b0; if0.instr = 32'h0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.instr = 32'h0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.instr = 32'h0; if2.out_ready = 1'b1;

        // Reset state.
        #12;
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_imm",       if0.imm,            64'd0);
        chk("rst_fmt",       64'(if0.fmt),       64'd0);
        chk("rst_err",       64'(if0.err),       64'd0);
        chk("rst_err_count", 64'(if0.err_count), 64'd0);
        chk("rst_in_ready",  64'(if0.in_ready),  64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven decode, back-to-back with out_ready=1.
        for (int i = 0; i < 9; i++) begin
            if0.in_valid = 1'b1; if0.instr = vecs[i].instr;
            if1.in_valid = 1'b1; if1.instr = vecs[i].instr;
            if (vecs[i].err) exp_cnt++;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 64'(if0.out_valid), 64'd1);
            chk($sformatf("v%0d_imm_sb0", i),   if0.imm,            vecs[i].imm0);
            chk($sformatf("v%0d_fmt_sb0", i),   64'(if0.fmt),       64'(vecs[i].fmt));
            chk($sformatf("v%0d_err_sb0", i),   64'(if0.err),       64'(vecs[i].err));
            chk($sformatf("v%0d_cnt_sb0", i),   64'(if0.err_count), 64'(exp_cnt));
            chk($sformatf("v%0d_imm_sb1", i),   if1.imm,            vecs[i].imm1);
            chk($sformatf("v%0d_fmt_sb1", i),   64'(if1.fmt),       64'(vecs[i].fmt));
        end
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", 64'(if0.out_valid), 64'd0);

        // Backpressure: accept one word, then stall for three cycles.
        if0.in_valid = 1'b1; if0.instr = 32'hF84FFFFF;
        @(negedge clk);
        chk("bp_first_imm", if0.imm, 64'hFF);
        if0.out_ready = 1'b0;
        if0.instr = 32'hB47FFFFF;
        #1;
        chk("bp_in_ready_low", 64'(if0.in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d_imm", c),      if0.imm,            64'hFF);
            chk($sformatf("bp_stall%0d_fmt", c),      64'(if0.fmt),       64'd1);
            chk($sformatf("bp_stall%0d_valid", c),    64'(if0.out_valid), 64'd1);
            chk($sformatf("bp_stall%0d_in_ready", c), 64'(if0.in_ready),  64'd0);
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_imm", if0.imm,      64'h3FFFF);
        chk("bp_release_fmt", 64'(if0.fmt), 64'd2);

        // Back-to-back stream of four words.
        stream[0] = 64'h0000_0000_0000_0FFF;
        stream[1] = 64'hFFFF_FFFF_FFFF_FF00;
        stream[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        stream[3] = 64'h0000_0000_0000_00FF;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       if0.instr = 32'h913FFC00;
                1:       if0.instr = 32'hF8500000;
                2:       if0.instr = 32'h17FFFFFF;
                default: if0.instr = 32'hF80FFFFF;
            endcase
            @(negedge clk);
            chk($sformatf("stream%0d_valid", s), 64'(if0.out_valid), 64'd1);
            chk($sformatf("stream%0d_imm", s),   if0.imm,            stream[s]);
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("stream_end_valid", 64'(if0.out_valid), 64'd0);

        // Counter saturation on the 2-bit instance.
        if2.in_valid = 1'b1; if2.instr = 32'hF83FFFFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("sat%0d_cnt", k), 64'(if2.err_count), 64'((k < 3) ? (k + 1) : 3));
            chk($sformatf("sat%0d_err", k), 64'(if2.err),       64'd1);
        end
        if2.in_valid = 1'b0;

        // Asynchronous reset while a result is stalled.
        if0.in_valid = 1'b1; if0.instr = 32'hF84FFFFF;
        @(negedge clk);
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(if0.out_valid), 64'd1);
        chk("pre_rst_cnt",   64'(if0.err_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(if0.out_valid), 64'd0);
        chk("async_rst_imm",   if0.imm,            64'd0);
        chk("async_rst_cnt",   64'(if0.err_count), 64'd0);
        chk("async_rst_cnt2",  64'(if2.err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the LEGv8 datapath, and the successor to the combinational signext. It decodes D, CB, B and I formats from a 32-bit instruction word and sign- or zero-extends the immediate to N bits. The result is delivered through a one-stage valid/ready register, together with a format tag, an error flag and a saturating error counter. It sits between fetch/decode and the register-read stage.

Parameters:
N, 64, output immediate width; legal range N >= 32 (elaboration-time assertion otherwise).
SHIFT_BRANCH, 0, when 1 CB/B offsets are shifted left by 2 before extension; when 0 raw offset.
ERR_CNT_W, 8, width of saturating error counter.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instr is valid this cycle
in_ready  out  1  stage can accept instr this cycle
instr  in  32  instruction word
out_valid  out  1  imm/fmt/err hold a valid result
out_ready  in  1  consumer accepts result this cycle
imm  out  N  extended immediate
fmt  out  3  0 NONE, 1 D, 2 CB, 3 B, 4 I
err  out  1  result came from an unrecognised opcode
err_count  out  ERR_CNT_W  accepted unrecognised instructions, saturating

Behaviour:
- Reset (async, high): out_valid=0, imm=0, fmt=0, err=0, err_count=0. A result held at reset is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready. The result appears on the next edge: 1-cycle latency, out_valid=1.
- Full-throughput: accepting and draining in the same cycle is legal; the register reloads with no bubble.
- Stall: out_valid && !out_ready -> imm, fmt and err stay stable and in_ready=0.
- No accept && out_ready -> out_valid clears; imm/fmt/err keep their last value (don't-care).
- Decode, first match wins, evaluated on instr:
  - D: instr[31:21] in {11'h7C2 LDUR, 11'h7C0 STUR} -> sext(instr[20:12]), fmt=1.
  - CB: instr[31:24] in {8'hB4 CBZ, 8'hB5 CBNZ} -> off=instr[23:5]; fmt=2.
  - B: instr[31:26]=6'b000101 -> off=instr[25:0]; fmt=3.
  - I: instr[31:22] in {10'b1001000100 ADDI, 10'b1101000100 SUBI} -> zero-extend instr[21:10], fmt=4.
  - Otherwise: imm=0, fmt=0, err=1.
- CB/B: with SHIFT_BRANCH=1 the value is sext({off,2'b00}); with SHIFT_BRANCH=0 it is sext(off). Sign bit is the MSB of the (shifted) field.
- err=0 for all recognised formats.
- err_count increments by 1 on each accepted unrecognised instr. It holds at 2^ERR_CNT_W-1 and never wraps. It counts at accept time, not drain time.

Test Plan:
- Reset, N=64, SHIFT_BRANCH=0, out_ready=1. Send 0xF84FFFFF -> next cycle imm=0x00000000000000FF, fmt=1, err=0. Send 0xF8500000 -> imm=0xFFFFFFFFFFFFFF00, fmt=1. Send 0xF80FFFFF (STUR) -> imm=0xFF.
- CB/B, SHIFT_BRANCH=0: 0xB47FFFFF -> imm=0x3FFFF, fmt=2. 0xB5FFFFE0 -> imm=0xFFFFFFFFFFFFFFFF. 0x17FFFFFF -> all ones, fmt=3. Repeat with SHIFT_BRANCH=1: results 0xFFFFC, ...FFFC, ...FFFC respectively.
- I and unknown: 0x913FFC00 -> imm=0xFFF, fmt=4, err=0. 0xF83FFFFF -> imm=0, fmt=0, err=1, err_count=1. 0xBC1FFFFF -> err=1, err_count=2.
- Backpressure: accept 0xF84FFFFF, then hold out_ready=0 for 3 cycles with in_valid=1 and instr=0xB47FFFFF. Output must stay imm=0xFF and in_ready must stay 0. Raise out_ready -> next cycle imm=0x3FFFF. Back-to-back stream of 4 words with out_ready=1 -> 4 consecutive valid cycles.
- Saturation, ERR_CNT_W=2: 5 accepted unknown words -> err_count sequence 1,2,3,3,3.
- Reset mid-stall: out_valid=1, out_ready=0, assert reset between edges -> out_valid, imm, err_count go to 0 immediately (async).
